// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and FSM state type for the RSA operand stream
package rsa_pkg;

  localparam int KEY_W  = 1024;
  localparam int WORD_W = 32;
  localparam int WORDS  = KEY_W / WORD_W;

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    START     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    UNLOAD    = 3'd4
  } state_e;

endpackage

// File: rtl/rsa_word_serializer.sv
// rtl/rsa_word_serializer.sv - result register and word-serial valid/ready output stream
// Holds the captured result and emits it least-significant word first.
module rsa_word_serializer
  import rsa_pkg::*;
#(
  parameter int KEY_W  = rsa_pkg::KEY_W,
  parameter int WORD_W = rsa_pkg::WORD_W
) (
  input  logic              clk_slow,
  input  logic              reset,
  input  logic              capture,
  input  logic [KEY_W-1:0]  result_in,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              done
);

  localparam int WORDS = KEY_W / WORD_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  logic [KEY_W-1:0] res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  always_comb begin
    res_d   = res_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done    = 1'b0;
    if (capture) begin
      res_d   = result_in;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        valid_d = 1'b0;
        done    = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_slow or negedge reset) begin
    if (!reset) begin
      res_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Data is a pure function of registered state, so it cannot move during a stall.
  assign out_data  = res_q[int'(idx_q) * WORD_W +: WORD_W];
  assign out_valid = valid_q;
  assign out_last  = valid_q && (idx_q == IDX_LAST);

endmodule

// File: rtl/rsa_operand_stream.sv
// rtl/rsa_operand_stream.sv - operand loader and launch FSM around the 1024-bit modular exponentiator
// Optional exp_cycles busy-cycle counter: RSA_OPERAND_STREAM_CYCLE_CNT_EN
module rsa_operand_stream
  import rsa_pkg::*;
#(
  parameter int KEY_W  = rsa_pkg::KEY_W,
  parameter int WORD_W = rsa_pkg::WORD_W
) (
  input  logic              clk_slow,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              exp_go,
  output logic [KEY_W-1:0]  exp_M,
  output logic [KEY_W-1:0]  exp_e,
  output logic [KEY_W-1:0]  exp_N,
  input  logic [KEY_W-1:0]  exp_out,
  input  logic              exp_finished,
  output logic              busy
`ifdef RSA_OPERAND_STREAM_CYCLE_CNT_EN
  ,
  output logic [31:0]       exp_cycles
`endif
);

  localparam int WORDS = KEY_W / WORD_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(3 * WORDS);
  localparam int SEL_W = CNT_W - IDX_W;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(3 * WORDS - 1);
  localparam logic [SEL_W-1:0] SEL_M = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_E = SEL_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             exp_go_q, exp_go_d;
  logic [KEY_W-1:0] exp_m_q, exp_m_d;
  logic [KEY_W-1:0] exp_e_q, exp_e_d;
  logic [KEY_W-1:0] exp_n_q, exp_n_d;
  logic             in_xfer;
  logic             capture;
  logic             ser_done;
  logic [IDX_W-1:0] word_idx;
  logic [SEL_W-1:0] op_sel;

  assign in_xfer  = in_valid && in_ready_q;
  assign word_idx = cnt_q[IDX_W-1:0];
  assign op_sel   = cnt_q[CNT_W-1:IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_m_d = exp_m_q;
    exp_e_d = exp_e_q;
    exp_n_d = exp_n_q;
    capture = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_xfer) begin
          // Upper counter bits pick the operand, lower bits the word within it.
          if (op_sel == SEL_M) begin
            exp_m_d[int'(word_idx) * WORD_W +: WORD_W] = in_data;
          end else if (op_sel == SEL_E) begin
            exp_e_d[int'(word_idx) * WORD_W +: WORD_W] = in_data;
          end else begin
            exp_n_d[int'(word_idx) * WORD_W +: WORD_W] = in_data;
          end
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (!exp_finished) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (exp_finished) begin
          capture = 1'b1;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (ser_done) state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_comb begin
    in_ready_d = (state_d == LOAD);
    exp_go_d   = (state_d == START) || (state_d == WAIT_ACK);
  end

  always_ff @(posedge clk_slow or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      exp_go_q   <= 1'b0;
      exp_m_q    <= '0;
      exp_e_q    <= '0;
      exp_n_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      exp_go_q   <= exp_go_d;
      exp_m_q    <= exp_m_d;
      exp_e_q    <= exp_e_d;
      exp_n_q    <= exp_n_d;
    end
  end

  rsa_word_serializer #(
    .KEY_W (KEY_W),
    .WORD_W(WORD_W)
  ) u_serializer (
    .clk_slow (clk_slow),
    .reset    (reset),
    .capture  (capture),
    .result_in(exp_out),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .done     (ser_done)
  );

  assign in_ready = in_ready_q;
  assign exp_go   = exp_go_q;
  assign exp_M    = exp_m_q;
  assign exp_e    = exp_e_q;
  assign exp_N    = exp_n_q;
  assign busy     = (state_q != LOAD);

`ifdef RSA_OPERAND_STREAM_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_d == START) begin
      cyc_d = '0;
    end else if (((state_q == WAIT_ACK) || (state_q == WAIT_DONE)) && (cyc_q != '1)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk_slow or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign exp_cycles = cyc_q;
`endif

endmodule

// File: doc/rsa_operand_stream.md
Name: rsa_operand_stream

Overview:
- Word-serial front/back end for the 1024-bit modular exponentiator (C = M^e mod N).
- Assembles M, e and N from a 32-bit valid/ready input stream, then launches the exponentiator with a level go.
- Captures the result when the exponentiator finishes and returns it as a 32-bit valid/ready output stream.
- Sits between the bus-side register/DMA logic and the exponentiator, on the same clk_slow domain.

Parameters:
- KEY_W, 1024: operand/result width; must be a multiple of WORD_W.
- WORD_W, 32: stream word width.
- WORDS, KEY_W/WORD_W (32): words per operand (derived; do not override).

Ports:
- clk_slow  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  WORD_W  operand word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a word this cycle.
- out_data  out  WORD_W  result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  high with the final result word.
- exp_go  out  1  go to the exponentiator (level; the exponentiator edge-detects it).
- exp_M, exp_e, exp_N  out  KEY_W each  operand registers, held stable from launch to finish.
- exp_out  in  KEY_W  exponentiator result.
- exp_finished  in  1  exponentiator idle/done (1 in idle, 0 while busy).
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (async, reset==0), all registers cleared: state=LOAD, word counter=0, in_ready=0 during reset then 1, out_valid=0, out_last=0, exp_go=0, busy=0, exp_M/e/N=0, result register=0.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready transfer writes one word.
  - Words 0..31 go to M, 32..63 to e, 64..95 to N; least-significant word first within each operand (word k -> bits [32k+31:32k]).
  - The counter is 7 bits; on the 96th transfer it resets to 0 and the state moves to START on the next edge.
  - in_valid while in_ready=0 is ignored; upstream must hold the word.
- START: exp_go=1, in_ready=0. Move to WAIT_ACK next cycle.
- WAIT_ACK:
  - exp_go held at 1 until exp_finished==0 is sampled.
  - Then exp_go<=0 and the state moves to WAIT_DONE.
  - No timeout.
- WAIT_DONE: on the first cycle with exp_finished==1, capture exp_out into the result register, then go to UNLOAD.
- UNLOAD:
  - out_valid=1; out_data = result word[counter], LS word first.
  - Each out_valid&out_ready transfer advances the counter.
  - out_last=1 when counter==31.
  - out_data and out_valid stay stable while out_ready=0.
  - After the last transfer: counter=0, out_valid=0, state=LOAD, in_ready=1 on the following cycle.
- Latency:
  - Last input word to exp_go=1: 1 cycle.
  - exp_finished rise to first out_valid: 1 cycle.
- exp_M/e/N change only in LOAD, so they are stable for the whole exponentiation.
- Reset asserted mid-operation aborts immediately:
  - exp_go drops and partial operands are cleared.
  - The exponentiator shares the reset and also returns to Stop.
- Illegal state encoding recovers to LOAD.

Optional Feature:
- Macro RSA_OPERAND_STREAM_CYCLE_CNT_EN.
- When defined:
  - Adds output port exp_cycles [31:0] (reset 0).
  - Cleared on entry to START; increments every cycle in WAIT_ACK and WAIT_DONE; saturates at 0xFFFF_FFFF.
  - Holds its value through UNLOAD and LOAD until the next START.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rsa_pkg:
  - KEY_W/WORD_W/WORDS constants.
  - State typedef: LOAD=0, START=1, WAIT_ACK=2, WAIT_DONE=3, UNLOAD=4.
- One natural sub-module, rsa_word_serializer: result register plus UNLOAD counter, out_valid/out_ready/out_last logic.
- The loader and FSM stay in the top level.

Test Plan:
- Bench uses a behavioural exponentiator model: edge-detects go, drops finished one cycle later, raises it after a configurable N cycles.
- Stream M=4, e=13, N=497 (upper words 0) -> exp_go high 1 cycle after word 95; result word0=0x000001BD (445), words1..31=0, out_last on word 31.
- M=5, e=0, N=7 -> result word0=1; model latency 1 vs 5000 cycles both give the correct single launch (exp_go deasserts only after finished seen 0).
- Random in_valid gaps and out_ready held low 10 cycles mid-unload -> no lost/duplicated words; out_data stable while stalled; in_ready=0 from START through UNLOAD.
- Assert reset in WAIT_DONE and midway through LOAD (word 40) -> all outputs at reset values next cycle; a fresh 96-word load then produces the correct result.
- With RSA_OPERAND_STREAM_CYCLE_CNT_EN and model latency 100 -> exp_cycles=101 (WAIT_ACK 1 + WAIT_DONE 100), held until next START; absent when undefined.
